mem_bus_ctrl: RTL

Single-master memory bus controller for the MIPS CPU. Arbitrates the one shared memory port between instruction fetch and data load/store, and sequences each access through a waitrequest handshake. It also generates byte enables and byte-lane alignment for stores, and performs sign/zero extension and LWL/LWR merging for loads. It sits between the CPU core (fetch stage, memory stage) and the external memory bus.

---
 rtl/mem_bus_ctrl_pkg.sv | 29 ++
 rtl/mem_lane_align.sv | 101 ++++++++++
 rtl/mem_bus_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types for the MIPS memory bus controller.
// Opcode and state encodings plus lane geometry constants.
package mem_bus_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  typedef enum logic [5:0] {
    OP_LB  = 6'b100000,
    OP_LH  = 6'b100001,
    OP_LWL = 6'b100010,
    OP_LW  = 6'b100011,
    OP_LBU = 6'b100100,
    OP_LHU = 6'b100101,
    OP_LWR = 6'b100110,
    OP_SB  = 6'b101000,
    OP_SH  = 6'b101001,
    OP_SW  = 6'b101011
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS_FETCH,
    ST_BUS_DATA,
    ST_RESP
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and extension/merge for loads.
// MEM_BUS_CTRL_LWLR_EN enables the LWL/LWR merge path.
module mem_lane_align
  import mem_bus_ctrl_pkg::*;
(
  input  logic [5:0]        opcode,
  input  logic [1:0]        b,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] readdata,
  input  logic [DATA_W-1:0] rt_old,
  output logic [DATA_W-1:0] writedata,
  output logic [LANES-1:0]  byteenable,
  output logic [DATA_W-1:0] rdata,
  output logic              store,
  output logic              err
);

  logic [4:0]        sh_r;
  logic [DATA_W-1:0] rsh;
  logic              keep;

  assign sh_r = {b, 3'b000};
  assign rsh  = readdata >> sh_r;

`ifdef MEM_BUS_CTRL_LWLR_EN
  logic [4:0]        sh_l;
  logic [DATA_W-1:0] lwl;
  logic [DATA_W-1:0] lwr;

  assign sh_l = {~b, 3'b000};
  assign lwl  = (readdata << sh_l)
              | (rt_old & ~(32'hFFFF_FFFF << sh_l));
  assign lwr  = rsh
              | (rt_old & ~(32'hFFFF_FFFF >> sh_r));
`endif

  // Decode opcode into lane enables, store data, load result and error.
  always_comb begin
    writedata  = '0;
    byteenable = '0;
    rdata      = '0;
    store      = 1'b0;
    err        = 1'b0;
    keep       = 1'b0;
    case (opcode)
      OP_LB: begin
        byteenable = 4'b1111;
        rdata      = {{24{rsh[7]}}, rsh[7:0]};
      end
      OP_LBU: begin
        byteenable = 4'b1111;
        rdata      = {24'h0, rsh[7:0]};
      end
      OP_LH: begin
        byteenable = 4'b1111;
        err        = b[0];
        rdata      = {{16{rsh[15]}}, rsh[15:0]};
      end
      OP_LHU: begin
        byteenable = 4'b1111;
        err        = b[0];
        rdata      = {16'h0, rsh[15:0]};
      end
      OP_LW: begin
        byteenable = 4'b1111;
        err        = |b;
        rdata      = readdata;
      end
      OP_LWL, OP_LWR: begin
`ifdef MEM_BUS_CTRL_LWLR_EN
        byteenable = 4'b1111;
        rdata      = (opcode == OP_LWL) ? lwl : lwr;
`else
        err        = 1'b1;
        keep       = 1'b1;
        rdata      = rt_old;
`endif
      end
      OP_SB: begin
        store      = 1'b1;
        byteenable = 4'b0001 << b;
        writedata  = {4{wdata[7:0]}};
      end
      OP_SH: begin
        store      = 1'b1;
        err        = b[0];
        byteenable = b[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{wdata[15:0]}};
      end
      OP_SW: begin
        store      = 1'b1;
        err        = |b;
        byteenable = 4'b1111;
        writedata  = wdata;
      end
      default: err = 1'b1;
    endcase
    if (err && !keep) rdata = '0;
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Fetch/data arbiter and waitrequest sequencer for the shared memory port.
// Build option: MEM_BUS_CTRL_LWLR_EN (LWL/LWR merge support).
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_instr,
  input  logic        dm_req,
  input  logic [5:0]  dm_opcode,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [31:0] dm_rt_old,
  output logic        dm_done,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  state_t state_q;
  state_t state_d;

  logic [5:0]  op_q;
  logic [31:0] daddr_q;
  logic [31:0] wdata_q;
  logic [31:0] rt_q;
  logic [31:0] faddr_q;
  logic        is_data_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] instr_q;

  logic        idle;
  logic [5:0]  a_op;
  logic [1:0]  a_b;
  logic [31:0] a_wdata;
  logic [31:0] a_rt;
  logic [31:0] a_wd_out;
  logic [3:0]  a_be;
  logic [31:0] a_rdata;
  logic        a_store;
  logic        a_err;

  assign idle    = (state_q == ST_IDLE);
  assign a_op    = idle ? dm_opcode    : op_q;
  assign a_b     = idle ? dm_addr[1:0] : daddr_q[1:0];
  assign a_wdata = idle ? dm_wdata     : wdata_q;
  assign a_rt    = idle ? dm_rt_old    : rt_q;

  mem_lane_align u_align (
    .opcode     (a_op),
    .b          (a_b),
    .wdata      (a_wdata),
    .readdata   (readdata),
    .rt_old     (a_rt),
    .writedata  (a_wd_out),
    .byteenable (a_be),
    .rdata      (a_rdata),
    .store      (a_store),
    .err        (a_err)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state: data wins arbitration, bad requests skip the bus.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dm_req)      state_d = a_err ? ST_RESP : ST_BUS_DATA;
        else if (if_req) state_d = ST_BUS_FETCH;
      end
      ST_BUS_FETCH,
      ST_BUS_DATA: begin
        if (!waitrequest) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the accepted request and register the access result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q      <= '0;
      daddr_q   <= '0;
      wdata_q   <= '0;
      rt_q      <= '0;
      faddr_q   <= '0;
      is_data_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      instr_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dm_req) begin
            op_q      <= dm_opcode;
            daddr_q   <= dm_addr;
            wdata_q   <= dm_wdata;
            rt_q      <= dm_rt_old;
            is_data_q <= 1'b1;
            err_q     <= a_err;
            rdata_q   <= a_rdata;
          end else if (if_req) begin
            faddr_q   <= if_addr;
            is_data_q <= 1'b0;
            err_q     <= 1'b0;
          end
        end
        ST_BUS_FETCH: begin
          if (!waitrequest) instr_q <= readdata;
        end
        ST_BUS_DATA: begin
          if (!waitrequest) rdata_q <= a_rdata;
        end
        default: ;
      endcase
    end
  end

  // Bus strobes and done pulses, all decoded from state.
  always_comb begin
    read       = 1'b0;
    write      = 1'b0;
    address    = '0;
    writedata  = '0;
    byteenable = '0;
    if_done    = 1'b0;
    dm_done    = 1'b0;
    dm_err     = 1'b0;
    case (state_q)
      ST_BUS_FETCH: begin
        read       = 1'b1;
        address    = faddr_q & ~32'h3;
        byteenable = 4'b1111;
      end
      ST_BUS_DATA: begin
        read       = !a_store;
        write      = a_store;
        address    = daddr_q & ~32'h3;
        byteenable = a_be;
        writedata  = a_store ? a_wd_out : '0;
      end
      ST_RESP: begin
        if_done = !is_data_q;
        dm_done = is_data_q;
        dm_err  = is_data_q & err_q;
      end
      default: ;
    endcase
  end

  assign if_instr = instr_q;
  assign dm_rdata = rdata_q;

endmodule
